redmule_x_loader: RTL and testbench

REDMULE_X_LOADER -- requirements
Module: redmule_x_loader

---
 rtl/redmule_x_loader.sv | 162 ++++++++++++++++
 tb/tb_redmule_x_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_x_loader.sv
// redmule_x_loader
// Moves X rows from the streamer into the X buffer one tile at a time.
// Each tile streams its effective number of rows, zero-pads up to the tile
// width, then waits for the X buffer to report full before the row index is
// reset and the next tile begins.
// Optional feature macro: REDMULE_X_LOADER_PERF_EN adds two saturating
// performance counters (stream stall cycles and buffer-full wait cycles).
module redmule_x_loader #(
    parameter int DW = 288,
    parameter int W  = 12,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [CW-1:0] cfg_width_i,
    input  logic [CW-1:0] cfg_last_width_i,
    input  logic [15:0]   cfg_tiles_i,
    input  logic [DW-1:0] stream_data_i,
    input  logic          stream_valid_i,
    output logic          stream_ready_o,
    output logic [DW-1:0] xbuf_data_o,
    output logic          xbuf_load_o,
    input  logic          xbuf_full_i,
    output logic          xbuf_rst_w_index_o,
    output logic          pad_setup_o,
    output logic          busy_o,
    output logic          done_o
`ifdef REDMULE_X_LOADER_PERF_EN
    ,
    output logic [31:0]   perf_stall_o,
    output logic [31:0]   perf_wait_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ZPAD,
        WAIT_FULL,
        DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cfg_width;
    logic [CW-1:0]   r_cfg_last;
    logic [15:0]     r_cfg_tiles;
    logic [CW-1:0]   r_row_cnt;
    logic [15:0]     r_tile_cnt;
    logic [DW-1:0]   r_xbuf_data;
    logic            r_xbuf_load;

    logic            w_last_tile;
    logic [CW-1:0]   w_eff;
    logic [CW-1:0]   w_row_next;
    logic            w_ack;

    // The final tile may stream fewer rows; a zero or oversized last width
    // falls back to the full tile width.
    assign w_last_tile = (r_tile_cnt == (r_cfg_tiles - 16'd1));
    assign w_eff       = (w_last_tile && (r_cfg_last != '0) && (r_cfg_last < r_cfg_width))
                         ? r_cfg_last : r_cfg_width;
    assign w_row_next  = r_row_cnt + CW'(1);

    // Full is only meaningful while waiting for it; elsewhere it is ignored.
    assign w_ack       = (r_state == WAIT_FULL) && xbuf_full_i;

    assign stream_ready_o     = (r_state == LOAD);
    assign busy_o             = (r_state != IDLE);
    assign done_o             = (r_state == DONE);
    assign xbuf_rst_w_index_o = w_ack;
    assign pad_setup_o        = w_ack && (r_tile_cnt == 16'd0);
    assign xbuf_data_o        = r_xbuf_data;
    assign xbuf_load_o        = r_xbuf_load;

    // Main sequencer: job acceptance, row streaming, zero padding and tile handoff.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= IDLE;
            r_cfg_width <= '0;
            r_cfg_last  <= '0;
            r_cfg_tiles <= '0;
            r_row_cnt   <= '0;
            r_tile_cnt  <= '0;
            r_xbuf_data <= '0;
            r_xbuf_load <= 1'b0;
        end else begin
            r_xbuf_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_cfg_width <= cfg_width_i;
                        r_cfg_last  <= cfg_last_width_i;
                        r_cfg_tiles <= cfg_tiles_i;
                        r_row_cnt   <= '0;
                        r_tile_cnt  <= '0;
                        r_state     <= (cfg_tiles_i == 16'd0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (stream_valid_i) begin
                        r_xbuf_data <= stream_data_i;
                        r_xbuf_load <= 1'b1;
                        r_row_cnt   <= w_row_next;
                        if (w_row_next >= w_eff) begin
                            r_state <= (w_eff < r_cfg_width) ? ZPAD : WAIT_FULL;
                        end
                    end
                end
                ZPAD: begin
                    r_xbuf_data <= '0;
                    r_xbuf_load <= 1'b1;
                    r_row_cnt   <= w_row_next;
                    if (w_row_next >= r_cfg_width) begin
                        r_state <= WAIT_FULL;
                    end
                end
                WAIT_FULL: begin
                    if (xbuf_full_i) begin
                        r_row_cnt  <= '0;
                        r_tile_cnt <= r_tile_cnt + 16'd1;
                        r_state    <= w_last_tile ? DONE : LOAD;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef REDMULE_X_LOADER_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_wait;

    assign perf_stall_o = r_perf_stall;
    assign perf_wait_o  = r_perf_wait;

    // Saturating counters of stream stalls and buffer-full waits, restarted per job.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_perf_stall <= '0;
            r_perf_wait  <= '0;
        end else if ((r_state == IDLE) && start_i) begin
            r_perf_stall <= '0;
            r_perf_wait  <= '0;
        end else begin
            if ((r_state == LOAD) && !stream_valid_i && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((r_state == WAIT_FULL) && (r_perf_wait != '1)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_redmule_x_loader.sv
// tb_redmule_x_loader
// Drives randomized row streams and an X buffer model around redmule_x_loader
// and compares the observed load sequence and handshake pulses against the
// row layout expected for each job. Perf counter checks apply only when
// REDMULE_X_LOADER_PERF_EN is defined.
module tb_redmule_x_loader;

    localparam int DW = 288;
    localparam int W  = 12;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] cfg_width_i = '0;
    logic [CW-1:0] cfg_last_width_i = '0;
    logic [15:0]   cfg_tiles_i = '0;
    logic [DW-1:0] stream_data_i = '0;
    logic          stream_valid_i = 1'b0;
    logic          stream_ready_o;
    logic [DW-1:0] xbuf_data_o;
    logic          xbuf_load_o;
    logic          xbuf_full_i;
    logic          xbuf_rst_w_index_o;
    logic          pad_setup_o;
    logic          busy_o;
    logic          done_o;
`ifdef REDMULE_X_LOADER_PERF_EN
    logic [31:0]   perf_stall_o;
    logic [31:0]   perf_wait_o;
`endif

    int nVectors = 0;
    int nMiscompares = 0;
    int cycle = 0;

    // Stream source state
    logic [DW-1:0] srcBeats[$];
    int            srcIdx = 0;
    bit            srcEnable = 1'b0;
    int            stallPct = 0;

    // X buffer model and observation state
    logic [DW-1:0] loadQ[$];
    int  loadCount = 0;
    int  ackCount = 0;
    int  padCount = 0;
    int  padStray = 0;
    int  doneCount = 0;
    int  readyCount = 0;
    int  stallModel = 0;
    int  lastAckCycle = 0;
    int  lastDoneCycle = 0;
    int  bufRows = 0;
    int  curWidth = 0;
    int  fullCountdown = 0;
    bit  dropFull = 1'b0;
    bit  modelFull = 1'b0;
    bit  spuriousFull = 1'b0;

    assign xbuf_full_i = modelFull | spuriousFull;

    redmule_x_loader #(.DW(DW), .W(W), .CW(CW)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .start_i            (start_i),
        .cfg_width_i        (cfg_width_i),
        .cfg_last_width_i   (cfg_last_width_i),
        .cfg_tiles_i        (cfg_tiles_i),
        .stream_data_i      (stream_data_i),
        .stream_valid_i     (stream_valid_i),
        .stream_ready_o     (stream_ready_o),
        .xbuf_data_o        (xbuf_data_o),
        .xbuf_load_o        (xbuf_load_o),
        .xbuf_full_i        (xbuf_full_i),
        .xbuf_rst_w_index_o (xbuf_rst_w_index_o),
        .pad_setup_o        (pad_setup_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
`ifdef REDMULE_X_LOADER_PERF_EN
        ,
        .perf_stall_o       (perf_stall_o),
        .perf_wait_o        (perf_wait_o)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time pulses relative to each other
    always @(posedge clk) cycle++;

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    // Rows streamed into a tile: a short final tile only when last is 1..width-1
    function automatic int effRows(input int w, input int l, input bit isFinal);
        return (isFinal && l != 0 && l < w) ? l : w;
    endfunction

    // Streamer model: offers the next queued beat unless a random stall hits
    always @(posedge clk) begin
        #1;
        if (srcEnable && srcIdx < srcBeats.size() && int'($urandom_range(99)) >= stallPct) begin
            stream_valid_i = 1'b1;
            stream_data_i  = srcBeats[srcIdx];
        end else begin
            stream_valid_i = 1'b0;
            stream_data_i  = randBeat();
        end
    end

    // X buffer model: raises full two cycles after the last row of a tile lands
    always @(posedge clk) begin
        #1;
        if (dropFull) begin
            modelFull = 1'b0;
            dropFull  = 1'b0;
        end
        if (fullCountdown > 0) begin
            fullCountdown--;
            if (fullCountdown == 0) modelFull = 1'b1;
        end
    end

    // Monitor: samples all DUT outputs mid-cycle
    always @(negedge clk) begin
        if (xbuf_load_o) begin
            loadQ.push_back(xbuf_data_o);
            loadCount++;
            bufRows++;
            if (bufRows == curWidth) fullCountdown = 2;
        end
        if (xbuf_rst_w_index_o) begin
            ackCount++;
            lastAckCycle = cycle;
            bufRows = 0;
            dropFull = 1'b1;
        end
        if (pad_setup_o) begin
            padCount++;
            if (!xbuf_rst_w_index_o || ackCount != 1) padStray++;
        end
        if (done_o) begin
            doneCount++;
            lastDoneCycle = cycle;
        end
        if (stream_ready_o) begin
            readyCount++;
            if (!stream_valid_i) stallModel++;
        end
        if (stream_valid_i && stream_ready_o) srcIdx++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutputData(input string tag, input logic [DW-1:0] observed,
                                   input logic [DW-1:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetEnv();
        loadQ.delete();
        loadCount = 0; ackCount = 0; padCount = 0; padStray = 0;
        doneCount = 0; readyCount = 0; stallModel = 0;
        bufRows = 0; fullCountdown = 0; dropFull = 1'b0; modelFull = 1'b0;
        srcIdx = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, int'(busy_o), 0);
        checkOutput({tag, "_ready"}, int'(stream_ready_o), 0);
        checkOutput({tag, "_load"}, int'(xbuf_load_o), 0);
        checkOutput({tag, "_rstidx"}, int'(xbuf_rst_w_index_o), 0);
        checkOutput({tag, "_pad"}, int'(pad_setup_o), 0);
        checkOutput({tag, "_done"}, int'(done_o), 0);
        checkOutputData({tag, "_data"}, xbuf_data_o, '0);
    endtask

    // Builds the source stream and expected load sequence for a job
    task automatic buildJob(input int w, input int l, input int t,
                            output logic [DW-1:0] expQ[$]);
        logic [DW-1:0] b;
        int e;
        srcBeats.delete();
        expQ.delete();
        for (int tile = 0; tile < t; tile++) begin
            e = effRows(w, l, tile == t - 1);
            for (int r = 0; r < e; r++) begin
                b = randBeat();
                srcBeats.push_back(b);
                expQ.push_back(b);
            end
            for (int r = e; r < w; r++) expQ.push_back('0);
        end
    endtask

    task automatic applyStimulus(input int w, input int l, input int t, input int stall,
                                 input bit disturb);
        logic [DW-1:0] expQ[$];
        int startCycle;
        int n;
        buildJob(w, l, t, expQ);
        @(posedge clk); #2;
        resetEnv();
        curWidth  = w;
        stallPct  = stall;
        srcEnable = 1'b1;
        @(posedge clk); #2;
        start_i          = 1'b1;
        cfg_width_i      = CW'(w);
        cfg_last_width_i = CW'(l);
        cfg_tiles_i      = 16'(t);
        startCycle       = cycle;
        @(posedge clk); #2;
        start_i          = 1'b0;
        cfg_width_i      = CW'($urandom_range(1, W));
        cfg_last_width_i = CW'($urandom_range(0, W));
        cfg_tiles_i      = 16'($urandom_range(0, 5));
        if (disturb) begin
            for (int i = 0; i < 200 && loadCount < 2; i++) @(negedge clk);
            @(posedge clk); #2;
            spuriousFull = 1'b1;
            start_i      = 1'b1;
            cfg_tiles_i  = 16'd0;
            repeat (3) @(posedge clk);
            #2;
            spuriousFull = 1'b0;
            start_i      = 1'b0;
        end
        for (int i = 0; i < 4000 && doneCount == 0; i++) @(negedge clk);
        checkOutput("done_seen", int'(doneCount > 0), 1);
        repeat (3) @(negedge clk);
        checkOutput("load_count", loadCount, t * w);
        checkOutput("load_size", loadQ.size(), expQ.size());
        n = (loadQ.size() < expQ.size()) ? loadQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutputData("load_data", loadQ[i], expQ[i]);
        checkOutput("ack_count", ackCount, t);
        checkOutput("pad_count", padCount, (t > 0) ? 1 : 0);
        checkOutput("pad_stray", padStray, 0);
        checkOutput("done_count", doneCount, 1);
        if (t > 0) checkOutput("done_after_ack", lastDoneCycle, lastAckCycle + 1);
        else       checkOutput("done_after_start", lastDoneCycle, startCycle + 1);
        if (stall == 0) checkOutput("ready_cycles", readyCount, srcBeats.size());
        checkOutput("busy_after", int'(busy_o), 0);
`ifdef REDMULE_X_LOADER_PERF_EN
        checkOutput("perf_stall", int'(perf_stall_o), stallModel);
`endif
        srcEnable = 1'b0;
    endtask

    // Abandons a two-tile job in its second tile via reset or clear
    task automatic abortJob(input bit useClear);
        logic [DW-1:0] expQ[$];
        int loadsAtReset;
        buildJob(4, 0, 2, expQ);
        @(posedge clk); #2;
        resetEnv();
        curWidth  = 4;
        stallPct  = 0;
        srcEnable = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b1; cfg_width_i = CW'(4); cfg_last_width_i = '0; cfg_tiles_i = 16'd2;
        @(posedge clk); #2;
        start_i = 1'b0;
        for (int i = 0; i < 200 && loadCount < 7; i++) @(negedge clk);
        checkOutput("abort_reached", int'(loadCount >= 7), 1);
        @(posedge clk); #2;
        if (useClear) clear_i = 1'b1; else rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero(useClear ? "clear" : "reset");
        loadsAtReset = loadCount;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_i = 1'b0; clear_i = 1'b0; srcEnable = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_loads", loadCount, loadsAtReset);
        checkOutput("abort_no_done", doneCount, 0);
        checkOutput("abort_idle", int'(busy_o), 0);
    endtask

    // Directed sequence of jobs
    initial begin
        $display("[TB] starting redmule_x_loader bench");
        repeat (3) @(negedge clk);
        checkAllZero("por");
        @(posedge clk); #2;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("idle");

        applyStimulus(4, 0, 2, 0, 1'b0);
        applyStimulus(4, 2, 1, 0, 1'b0);
        applyStimulus(12, 0, 3, 30, 1'b0);
        applyStimulus(4, 0, 0, 0, 1'b0);
        abortJob(1'b0);
        applyStimulus(5, 3, 3, 20, 1'b0);
        abortJob(1'b1);
        applyStimulus(12, 0, 2, 0, 1'b1);
        applyStimulus(6, 9, 2, 0, 1'b0);
        applyStimulus(1, 0, 3, 0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus($urandom_range(1, W), $urandom_range(0, W), $urandom_range(1, 3),
                          $urandom_range(0, 40), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
